gshare_update_ctrl: RTL

//  Sequences the 2-bit-counter branch history table (prediction_array-style, 1R/1W,

---
 rtl/gshare_update_ctrl_if.sv | 49 ++++
 rtl/gshare_update_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/gshare_update_ctrl_if.sv
// gshare_update_ctrl_if: lookup, table-port, resolve and queue-status bundle.
// master = controller side (drives prediction, table write, ready, count); slave = pipe/table side.
interface gshare_update_ctrl_if #(
   parameter int S_INDEX  = 10,
   parameter int WIDTH    = 2,
   parameter int HIST_LEN = 8,
   parameter int QDEPTH   = 4
);
   localparam int CW = $clog2(QDEPTH) + 1;

   logic                fetch_valid;
   logic [31:0]         fetch_pc;
   logic                pred_taken;
   logic [S_INDEX-1:0]  pred_index;
   logic [WIDTH-1:0]    pred_ctr;
   logic [HIST_LEN-1:0] pred_ghr;
   logic [S_INDEX-1:0]  arr_rindex;
   logic [WIDTH-1:0]    arr_dataout;
   logic                arr_load;
   logic [S_INDEX-1:0]  arr_windex;
   logic [WIDTH-1:0]    arr_datain;
   logic                res_valid;
   logic                res_ready;
   logic [S_INDEX-1:0]  res_index;
   logic [WIDTH-1:0]    res_ctr;
   logic                res_taken;
   logic                res_mispred;
   logic [HIST_LEN-1:0] res_ghr;
   logic                upd_hold;
   logic [CW-1:0]       q_count;

   modport master (
      input  fetch_valid, fetch_pc, arr_dataout,
      input  res_valid, res_index, res_ctr, res_taken,
      input  res_mispred, res_ghr, upd_hold,
      output pred_taken, pred_index, pred_ctr, pred_ghr,
      output arr_rindex, arr_load, arr_windex, arr_datain,
      output res_ready, q_count
   );

   modport slave (
      output fetch_valid, fetch_pc, arr_dataout,
      output res_valid, res_index, res_ctr, res_taken,
      output res_mispred, res_ghr, upd_hold,
      input  pred_taken, pred_index, pred_ctr, pred_ghr,
      input  arr_rindex, arr_load, arr_windex, arr_datain,
      input  res_ready, q_count
   );
endinterface

// File: rtl/gshare_update_ctrl.sv
// gshare_update_ctrl: gshare read index + speculative GHR, coalescing BHT update queue.
// Ports: clk, rst (sync, active-high), bus (gshare_update_ctrl_if.master).
module gshare_update_ctrl #(
   parameter int S_INDEX  = 10,
   parameter int WIDTH    = 2,
   parameter int HIST_LEN = 8,
   parameter int QDEPTH   = 4
) (
   input logic                  clk,
   input logic                  rst,
   gshare_update_ctrl_if.master bus
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [WIDTH-1:0] CMAX = '1;

   logic [HIST_LEN-1:0] ghr;
   logic [S_INDEX-1:0]  idx_q [QDEPTH];
   logic [WIDTH-1:0]    ctr_q [QDEPTH];
   logic [PW-1:0]       head;
   logic [PW-1:0]       tail;
   logic [CW-1:0]       count;

   logic                deq;
   logic                ready;
   logic                accept;
   logic                push;
   logic                match_any;
   logic                match_head;
   logic [PW-1:0]       match_idx;
   logic [PW-1:0]       off;
   logic [S_INDEX-1:0]  rindex;
   logic                unused_bits;

   function automatic logic [WIDTH-1:0] sat(
      input logic [WIDTH-1:0] c,
      input logic             t
   );
      if (t)
         return (c == CMAX) ? c : c + WIDTH'(1);
      return (c == '0) ? c : c - WIDTH'(1);
   endfunction

   // gshare lookup is purely combinational and ignores fetch_valid
   assign rindex         = bus.fetch_pc[S_INDEX+1:2] ^ S_INDEX'(ghr);
   assign bus.arr_rindex = rindex;
   assign bus.pred_index = rindex;
   assign bus.pred_ctr   = bus.arr_dataout;
   assign bus.pred_taken = bus.arr_dataout[WIDTH-1];
   assign bus.pred_ghr   = ghr;

   assign deq    = ~bus.upd_hold & (count != '0);
   assign ready  = (count != CW'(QDEPTH)) | ~bus.upd_hold;
   assign accept = bus.res_valid & ready;

   // Coalescing keeps indices unique among live entries,
   // so a plain OR-scan finds the single match.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      off       = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         off = PW'(i) - head;
         if (({1'b0, off} < count) && (idx_q[i] == bus.res_index)) begin
            match_any = 1'b1;
            match_idx = PW'(i);
         end
      end
   end

   // A match on the head that leaves this edge must be re-queued
   // at the tail, seeded from the head's counter.
   assign match_head = match_any & deq & (match_idx == head);
   assign push       = accept & ~(match_any & ~match_head);

   assign bus.arr_load   = deq;
   assign bus.arr_windex = idx_q[head];
   assign bus.arr_datain = ctr_q[head];
   assign bus.res_ready  = ready;
   assign bus.q_count    = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         ghr   <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // A resolving mispredict squashes any same-cycle fetch
         if (accept & bus.res_mispred)
            ghr <= {bus.res_ghr[HIST_LEN-2:0], bus.res_taken};
         else if (bus.fetch_valid)
            ghr <= {ghr[HIST_LEN-2:0], bus.arr_dataout[WIDTH-1]};
         if (push)
            tail <= tail + PW'(1);
         if (deq)
            head <= head + PW'(1);
         count <= count + CW'(push) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         if (push) begin
            idx_q[tail] <= bus.res_index;
            ctr_q[tail] <= match_head ? sat(ctr_q[head], bus.res_taken)
                                      : sat(bus.res_ctr, bus.res_taken);
         end else begin
            ctr_q[match_idx] <= sat(ctr_q[match_idx], bus.res_taken);
         end
      end
   end

   assign unused_bits = ^{bus.fetch_pc[31:S_INDEX+2], bus.fetch_pc[1:0],
                          bus.res_ghr[HIST_LEN-1]};
endmodule
